mem_slice: RTL
==============

# mem_slice

Memory stage of the five-stage pipeline. Captures the execute stage's outputs in the EX/MEM register and owns the architectural flag register. Resolves conditional branches and drives a variable-latency data-memory handshake, stalling the pipe while an access is outstanding. Produces the MEM/WB register consumed by writeback.

## Interface
Parameters:
- none; all widths are fixed by the ISA (16-bit data and address, 16 registers).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute stage holds a real instruction
- WB_in  in  2  writeback controls: [0] RegWrite, [1] MemToReg
- M_in  in  3  memory controls: [0] MemRead, [1] MemWrite, [2] Branch
- addr, data, result  in  16 each  memory address, store data, ALU result
- flags  in  3  {zr, neg, ov} from the ALU
- fl_en  in  3  per-flag update enable, same bit order as flags
- PCbranch  in  16  branch target
- bcond  in  3  branch condition code
- rd  in  4  destination register
- stall  out  1  freeze PC, IF/ID and ID/EX; hold execute inputs
- br_taken  out  1  redirect PC; flush younger stages
- br_target  out  16  redirect address
- dmem_req, dmem_we  out  1 each  access request; write when set
- dmem_addr, dmem_wdata  out  16 each  access address and store data
- dmem_rdata  in  16  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- wb_valid, wb_regwrite  out  1 each  writeback valid; register write enable
- wb_rd  out  4  writeback destination register
- wb_data  out  16  writeback data
- flags_q  out  3  architectural {Z, N, V}

## Operation
- EX/MEM register: fields valid, WB, M, addr, data, result, PCbranch, bcond, rd.
  - Loads on each edge where stall=0.
  - Loaded valid = ex_valid & ~br_taken, which kills the wrong-path instruction following a taken branch.
- Flag register: on the same loading edge, if ex_valid & ~br_taken, each flags_q[i] with fl_en[i]=1 takes flags[i]. A branch therefore sees the flags of all older instructions.
- Branch conditions, evaluated on flags_q:
  - 000 NE (~Z); 001 EQ (Z); 010 GT (~Z&~N); 011 LT (N)
  - 100 GE (Z|~N); 101 LE (Z|N); 110 OV (V); 111 always
- br_taken = mem_valid & M[2] & cond. br_target = registered PCbranch. Both are combinational from registered state.
- A memory op exists when mem_valid & (M[0]|M[1]).
  - Drive dmem_req=1, dmem_we=M[1], dmem_addr=addr, dmem_wdata=data.
- Access FSM:
  - IDLE: on a memory op without ack, go to BUSY.
  - BUSY: wait for ack, then return to IDLE.
  - Ack in the first cycle (zero-wait memory) never leaves IDLE.
  - Request fields are held stable until ack.
- stall = memory op & ~dmem_ack.
- If MemRead and MemWrite are both set, treat the access as a write.
- MEM/WB register loads on each edge where stall=0:
  - wb_valid = mem_valid
  - wb_regwrite = mem_valid & WB[0]
  - wb_data = WB[1] ? dmem_rdata : result
  - wb_rd = rd
- On stall, MEM/WB loads a bubble: wb_valid=0, wb_regwrite=0, other fields held.

## Timing
- Reset (asynchronous):
  - all valid bits 0, FSM IDLE, flags_q=000
  - all data registers and wb_* outputs 0
  - stall, br_taken, dmem_req 0
- Latency, non-memory instruction: EX edge → MEM one cycle → wb_* valid the next cycle.
- Memory instruction with N wait cycles (ack in cycle N+1 of MEM): stall high N cycles; wb_* valid the cycle after ack.
- A branch resolves in its MEM cycle. Branches never stall (no memory op), so br_taken is high exactly one cycle.
- dmem_ack while dmem_req=0 is ignored.
- Reset mid-access abandons the request. The memory is reset by the same rst.

## Structure
- Shared package mem_pkg:
  - bcond encodings as an enum
  - FSM state enum {IDLE, BUSY}
  - bit-position constants for the WB and M fields
- One sub-module, branch_cond: combinational (bcond, flags_q) → cond, reusable by the hazard unit.

## Test plan
- ADD with fl_en=111, flags=100, then BEQ (bcond=001, PCbranch=0x0040) → br_taken=1 for one cycle, br_target=0x0040; the next instruction enters MEM with valid=0.
- Load, addr=0x0010, ack after 3 cycles with rdata=0xBEEF, WB=11, rd=5 → stall high 3 cycles, dmem_req stable; next cycle wb_data=0xBEEF, wb_rd=5, wb_regwrite=1.
- Store with zero-wait ack, data=0x1234 → dmem_we=1 for one cycle, stall never asserted, wb_regwrite=0.
- fl_en=001, flags=111 with flags_q=000 → flags_q=001; BGT (010) is then taken.
- Assert rst during BUSY → all outputs 0 immediately, FSM IDLE; a later load completes normally.
- bcond=111 with M[2]=0 → br_taken=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and field positions for the memory stage and its helpers.
// Branch condition codes, access FSM states, and control-field bit positions.
package mem_pkg;

    typedef enum logic [2:0] {
        BC_NE = 3'b000,
        BC_EQ = 3'b001,
        BC_GT = 3'b010,
        BC_LT = 3'b011,
        BC_GE = 3'b100,
        BC_LE = 3'b101,
        BC_OV = 3'b110,
        BC_AL = 3'b111
    } bcond_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } acc_state_e;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    localparam int M_MEMREAD  = 0;
    localparam int M_MEMWRITE = 1;
    localparam int M_BRANCH   = 2;

    // Flag vector ordering is {Z, N, V}.
    localparam int FL_Z = 2;
    localparam int FL_N = 1;
    localparam int FL_V = 0;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps a condition code and the {Z, N, V} flags to taken/not-taken.
// Purely combinational so the hazard unit can share it.
module branch_cond
    import mem_pkg::*;
(
    input  logic [2:0] bcond_i,
    input  logic [2:0] flags_i,
    output logic       cond_o
);

    logic z, n, v;

    assign z = flags_i[FL_Z];
    assign n = flags_i[FL_N];
    assign v = flags_i[FL_V];

    always_comb begin
        cond_o = 1'b0;
        case (bcond_e'(bcond_i))
            BC_NE:   cond_o = ~z;
            BC_EQ:   cond_o = z;
            BC_GT:   cond_o = ~z & ~n;
            BC_LT:   cond_o = n;
            BC_GE:   cond_o = z | ~n;
            BC_LE:   cond_o = z | n;
            BC_OV:   cond_o = v;
            BC_AL:   cond_o = 1'b1;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_slice.sv
// Memory stage: EX/MEM register, architectural flags, branch resolution,
// variable-latency data-memory handshake with stall, and the MEM/WB register.
module mem_slice
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [1:0]  WB_in,
    input  logic [2:0]  M_in,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    input  logic [15:0] result,
    input  logic [2:0]  flags,
    input  logic [2:0]  fl_en,
    input  logic [15:0] PCbranch,
    input  logic [2:0]  bcond,
    input  logic [3:0]  rd,
    output logic        stall,
    output logic        br_taken,
    output logic [15:0] br_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic [2:0]  flags_q
);

    logic        mem_valid_q, mem_valid_d;
    logic [1:0]  wb_ctl_q, wb_ctl_d;
    logic [2:0]  m_ctl_q, m_ctl_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] result_q, result_d;
    logic [15:0] pcbranch_q, pcbranch_d;
    logic [2:0]  bcond_q, bcond_d;
    logic [3:0]  rd_q, rd_d;
    logic [2:0]  flags_d;

    logic        wb_valid_d, wb_regwrite_d;
    logic [3:0]  wb_rd_d;
    logic [15:0] wb_data_d;

    acc_state_e  state_q, state_d;

    logic        load_en;
    logic        ex_live;
    logic        mem_op;
    logic        cond;

    branch_cond u_branch_cond (
        .bcond_i (bcond_q),
        .flags_i (flags_q),
        .cond_o  (cond)
    );

    assign mem_op    = mem_valid_q & (m_ctl_q[M_MEMREAD] | m_ctl_q[M_MEMWRITE]);
    assign stall     = mem_op & ~dmem_ack;
    assign load_en   = ~stall;
    assign br_taken  = mem_valid_q & m_ctl_q[M_BRANCH] & cond;
    assign br_target = pcbranch_q;
    // The instruction behind a taken branch is on the wrong path and enters MEM dead.
    assign ex_live   = ex_valid & ~br_taken;

    // Read+write together resolves to a write.
    assign dmem_req   = mem_op;
    assign dmem_we    = mem_op & m_ctl_q[M_MEMWRITE];
    assign dmem_addr  = addr_q;
    assign dmem_wdata = data_q;

    always_comb begin
        mem_valid_d = mem_valid_q;
        wb_ctl_d    = wb_ctl_q;
        m_ctl_d     = m_ctl_q;
        addr_d      = addr_q;
        data_d      = data_q;
        result_d    = result_q;
        pcbranch_d  = pcbranch_q;
        bcond_d     = bcond_q;
        rd_d        = rd_q;
        flags_d     = flags_q;
        if (load_en) begin
            mem_valid_d = ex_live;
            wb_ctl_d    = WB_in;
            m_ctl_d     = M_in;
            addr_d      = addr;
            data_d      = data;
            result_d    = result;
            pcbranch_d  = PCbranch;
            bcond_d     = bcond;
            rd_d        = rd;
            if (ex_live) begin
                for (int i = 0; i < 3; i++) begin
                    if (fl_en[i]) flags_d[i] = flags[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_op && !dmem_ack) state_d = ST_BUSY;
            ST_BUSY: if (dmem_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_rd_d       = wb_rd;
        wb_data_d     = wb_data;
        if (load_en) begin
            wb_valid_d    = mem_valid_q;
            wb_regwrite_d = mem_valid_q & wb_ctl_q[WB_REGWRITE];
            wb_rd_d       = rd_q;
            wb_data_d     = wb_ctl_q[WB_MEMTOREG] ? dmem_rdata : result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            wb_ctl_q    <= '0;
            m_ctl_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            result_q    <= '0;
            pcbranch_q  <= '0;
            bcond_q     <= '0;
            rd_q        <= '0;
            flags_q     <= '0;
            state_q     <= ST_IDLE;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            wb_ctl_q    <= wb_ctl_d;
            m_ctl_q     <= m_ctl_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            result_q    <= result_d;
            pcbranch_q  <= pcbranch_d;
            bcond_q     <= bcond_d;
            rd_q        <= rd_d;
            flags_q     <= flags_d;
            state_q     <= state_d;
            wb_valid    <= wb_valid_d;
            wb_regwrite <= wb_regwrite_d;
            wb_rd       <= wb_rd_d;
            wb_data     <= wb_data_d;
        end
    end

endmodule
